apb_req_arbiter: RTL and testbench

//  Shares one apb_master between NUM_REQ requesters, e.g. AXI4-Lite write and read paths.

---
 rtl/apb_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master between NUM_REQ requesters.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
//
//   state | meaning
//   IDLE  | no transfer; arbitrate among req_valid
//   XFER  | transfer owned by req_gnt; STREQ on first cycle, wait for PENABLE && PREADY
//   RESP  | req_done pulse visible; owner drops req_valid
module apb_req_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    req_gnt,
   output logic [NUM_REQ-1:0]    req_done,
   output logic [DW-1:0]         req_rdata,
   output logic                  req_err,
   output logic                  arb_busy,
   output logic                  STREQ,
   output logic                  SWRT,
   output logic                  SSEL,
   output logic [AW-1:0]         SADDR,
   output logic [DW-1:0]         SWDATA,
   input  logic [DW-1:0]         SRDATA,
   input  logic                  PENABLE,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        owner_q, owner_d;
   logic [PW-1:0]        win;
   logic [PW-1:0]        rr_ptr;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [DW-1:0]        rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 streq_q, streq_d;
   logic                 swrt_q, swrt_d;
   logic                 ssel_q, ssel_d;
   logic [AW-1:0]        saddr_q, saddr_d;
   logic [DW-1:0]        swdata_q, swdata_d;
   int                   idx;

`ifdef APB_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   logic [PW-1:0] rr_q, rr_d;
   assign rr_ptr = rr_q;
`endif

   // Scan from the highest offset down so the first set bit at/after rr_ptr wins.
   always_comb begin
      win = '0;
      idx = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_valid[idx]) win = PW'(idx);
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      streq_d  = 1'b0;
      swrt_d   = swrt_q;
      ssel_d   = ssel_q;
      saddr_d  = saddr_q;
      swdata_d = swdata_q;
`ifndef APB_ARB_FIXED_PRIO_EN
      rr_d     = rr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               owner_d  = win;
               gnt_d    = NUM_REQ'(1) << win;
               swrt_d   = req_write[win];
               saddr_d  = req_addr[int'(win)*AW +: AW];
               swdata_d = req_wdata[int'(win)*DW +: DW];
               ssel_d   = 1'b1;
               streq_d  = 1'b1;
               state_d  = XFER;
            end
         end
         XFER: begin
            if (PENABLE && PREADY) begin
               done_d  = gnt_q;
               rdata_d = swrt_q ? '0 : SRDATA;
               err_d   = PSLVERR;
               ssel_d  = 1'b0;
               gnt_d   = '0;
`ifndef APB_ARB_FIXED_PRIO_EN
               rr_d    = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
`endif
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         streq_q  <= 1'b0;
         swrt_q   <= 1'b0;
         ssel_q   <= 1'b0;
         saddr_q  <= '0;
         swdata_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         streq_q  <= streq_d;
         swrt_q   <= swrt_d;
         ssel_q   <= ssel_d;
         saddr_q  <= saddr_d;
         swdata_q <= swdata_d;
      end
   end

`ifndef APB_ARB_FIXED_PRIO_EN
   always_ff @(posedge PCLK) begin
      if (!PRESETn) rr_q <= '0;
      else          rr_q <= rr_d;
   end
`endif

   assign req_gnt   = gnt_q;
   assign req_done  = done_q;
   assign req_rdata = rdata_q;
   assign req_err   = err_q;
   assign arb_busy  = (state_q != IDLE);
   assign STREQ     = streq_q;
   assign SWRT      = swrt_q;
   assign SSEL      = ssel_q;
   assign SADDR     = saddr_q;
   assign SWDATA    = swdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small behavioural apb_master model.
module tb_apb_req_arbiter;
   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            PCLK = 1'b0;
   logic            PRESETn;
   logic [N-1:0]    req_valid, req_write, req_gnt, req_done;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   req_rdata, SWDATA, SRDATA;
   logic            req_err, arb_busy, STREQ, SWRT, SSEL, PENABLE, PREADY, PSLVERR;
   logic [AW-1:0]   SADDR;

   apb_req_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_gnt(req_gnt), .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
      .arb_busy(arb_busy), .STREQ(STREQ), .SWRT(SWRT), .SSEL(SSEL), .SADDR(SADDR),
      .SWDATA(SWDATA), .SRDATA(SRDATA), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // apb_master model: Idle -> Setup -> Access (waits_v extra cycles) -> Idle
   int unsigned phase, wcnt, waits_v;
   logic [DW-1:0] srdata_v;
   logic          err_v;
   always @(posedge PCLK) begin
      if (!PRESETn) begin
         phase <= 0;
         wcnt  <= 0;
      end else begin
         case (phase)
            0: if (STREQ) phase <= 1;
            1: begin phase <= 2; wcnt <= waits_v; end
            default: if (PREADY) phase <= 0; else wcnt <= wcnt - 1;
         endcase
      end
   end
   assign PENABLE = (phase == 2);
   assign PREADY  = (phase == 2) && (wcnt == 0);
   assign SRDATA  = srdata_v;
   assign PSLVERR = err_v;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
      cyc++;
   endtask

   typedef struct {
      int          req;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] srdata;
      logic        err;
      int          waits;
      logic [1:0]  exp_done;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v);
      int n, streqs, bad;
      logic got;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      req_valid[v.req] = 1'b1;
      req_write[v.req] = v.wr;
      req_addr[v.req*AW +: AW]  = v.addr;
      req_wdata[v.req*DW +: DW] = v.wdata;
      srdata_v = v.srdata; err_v = v.err; waits_v = v.waits;
      n = 1; streqs = 0; bad = 0; got = 1'b0;
      while (!got && n < 60) begin
         tick();
         n++;
         if (STREQ) streqs++;
         if (SSEL && (SADDR !== v.addr || SWRT !== v.wr || (v.wr && SWDATA !== v.wdata)
                      || req_gnt !== v.exp_done)) bad++;
         if (n == 2) begin
            req_addr  = ~req_addr;
            req_wdata = ~req_wdata;
            req_write = ~req_write;
         end
         if (req_done != '0) got = 1'b1;
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("done_vec", 32'(req_done), 32'(v.exp_done));
      chk("rdata", req_rdata, v.exp_rdata);
      chk("err", 32'(req_err), 32'(v.exp_err));
      chk("done_cycle", 32'(n), 32'(v.exp_lat));
      chk("streq_pulses", 32'(streqs), 32'd1);
      chk("xfer_stable", 32'(bad), 32'd0);
      chk("gnt_at_done", 32'(req_gnt), 32'd0);
      chk("busy_resp", 32'(arb_busy), 32'd1);
      req_valid = '0;
      tick();
      chk("busy_idle", 32'(arb_busy), 32'd0);
      chk("done_clear", 32'(req_done), 32'd0);
      chk("rdata_hold", req_rdata, v.exp_rdata);
      chk("err_hold", 32'(req_err), 32'(v.exp_err));
   endtask

   task automatic do_reset();
      PRESETn = 1'b0;
      req_valid = '0;
      tick();
      tick();
      chk("rst_gnt", 32'(req_gnt), 32'd0);
      chk("rst_done", 32'(req_done), 32'd0);
      chk("rst_rdata", req_rdata, 32'd0);
      chk("rst_err", 32'(req_err), 32'd0);
      chk("rst_busy", 32'(arb_busy), 32'd0);
      chk("rst_streq_ssel_swrt", {29'd0, STREQ, SSEL, SWRT}, 32'd0);
      chk("rst_saddr", SADDR, 32'd0);
      chk("rst_swdata", SWDATA, 32'd0);
      PRESETn = 1'b1;
   endtask

   task automatic wait_streq(output int at);
      int n = 0;
      while (!STREQ && n < 20) begin
         tick();
         n++;
      end
      chk("streq_seen", 32'(STREQ), 32'd1);
      at = cyc;
   endtask

   task automatic wait_done();
      int n = 0;
      while (req_done == '0 && n < 20) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(req_done != '0), 32'd1);
   endtask

   initial begin
      int at, last, cnt;
      logic [1:0] exp_g[4];
      PRESETn = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      srdata_v = '0; err_v = 1'b0; waits_v = 0;

      //          req wr addr          wdata         srdata        err wt done   rdata         err lat
      vecs[0] = '{1, 0, 32'h0000_0010, 32'h0,        32'hCAFE_F00D, 0, 0, 2'b10, 32'hCAFE_F00D, 0, 5};
      vecs[1] = '{0, 1, 32'h0000_0020, 32'h1234_5678, 32'h0,        0, 3, 2'b01, 32'h0,        0, 8};
      vecs[2] = '{0, 0, 32'h0000_0044, 32'h0,        32'hDEAD_BEEF, 1, 0, 2'b01, 32'hDEAD_BEEF, 1, 5};
      vecs[3] = '{1, 0, 32'h0000_0048, 32'h0,        32'h0BAD_F00D, 0, 1, 2'b10, 32'h0BAD_F00D, 0, 6};
      vecs[4] = '{1, 1, 32'h0000_0100, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0, 0, 2'b10, 32'h0,        0, 5};
      vecs[5] = '{0, 0, 32'h8000_0004, 32'h0,        32'h1357_9BDF, 0, 2, 2'b01, 32'h1357_9BDF, 0, 7};

      do_reset();
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // contention with both requesters held
`ifdef APB_ARB_FIXED_PRIO_EN
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      do_reset();
      srdata_v = 32'h5555_AAAA; err_v = 1'b0; waits_v = 0;
      req_write = '0;
      req_addr  = {32'h0000_0200, 32'h0000_0100};
      req_valid = 2'b11;
      last = 0;
      for (int g = 0; g < 4; g++) begin
         wait_streq(at);
         chk("cont_gnt", 32'(req_gnt), 32'(exp_g[g]));
         if (g > 0) chk("cont_gap", 32'(at - last), 32'd5);
         last = at;
         wait_done();
         chk("cont_done", 32'(req_done), 32'(exp_g[g]));
      end
      req_valid = 2'b10;
      wait_streq(at);
      chk("drop0_gnt", 32'(req_gnt), 32'b10);
      chk("drop0_saddr", SADDR, 32'h0000_0200);
      wait_done();
      chk("drop0_done", 32'(req_done), 32'b10);
      req_valid = '0;
      tick();

      // reset during XFER aborts without req_done
      req_valid = 2'b01; req_write = '0; req_addr = {32'h0, 32'h0000_0300};
      srdata_v = 32'h7777_0000;
      tick();
      tick();
      chk("pre_abort_busy", 32'(arb_busy), 32'd1);
      PRESETn = 1'b0;
      req_valid = '0;
      tick();
      chk("abort_gnt", 32'(req_gnt), 32'd0);
      chk("abort_ssel", 32'(SSEL), 32'd0);
      chk("abort_busy", 32'(arb_busy), 32'd0);
      PRESETn = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (req_done != '0 || arb_busy) cnt++;
      end
      chk("abort_no_done", 32'(cnt), 32'd0);
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
